// File: rtl/rng_arb_pkg.sv
// rtl/rng_arb_pkg.sv - shared types, LFSR constants and range-mask helper for rng_request_arbiter
package rng_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } arb_state_t;

    localparam int LFSR_W = 8;
    // x^8+x^6+x^5+x^4+1 as feedback taps on s[7], s[5], s[4], s[3]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h00;

    // Smallest 2^n-1 covering limit-1; a zero limit wraps to all-ones.
    function automatic logic [LFSR_W-1:0] mask_from_limit(input logic [LFSR_W-1:0] limit);
        logic [LFSR_W-1:0] m;
        m = limit - LFSR_W'(1);
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running XNOR-feedback Fibonacci LFSR
module lfsr_core
    import rng_arb_pkg::*;
#(
    parameter int WIDTH = LFSR_W
) (
    input  logic             clock_i,
    input  logic             reset_i,
    output logic [WIDTH-1:0] state
);

    // XNOR feedback keeps the all-zero seed legal; all-ones is the lockup state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= WIDTH'(LFSR_SEED);
        end else begin
            state <= {state[WIDTH-2:0], ~^(state & WIDTH'(LFSR_TAPS))};
        end
    end

endmodule

// File: rtl/rng_request_arbiter.sv
// rtl/rng_request_arbiter.sv - round-robin shared RNG with range reduction; RNG_ARB_REJECT_EN enables rejection sampling
module rng_request_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = 15
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] limit_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [WIDTH-1:0]         value_o,
    output logic                     busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t        state, state_next;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  limit_q;
    logic [WIDTH-1:0]  lfsr_state;

    logic              req_found;
    logic [PTR_W-1:0]  req_idx;
    logic [WIDTH-1:0]  req_limit;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  draw_m;
    logic              in_range;
    logic              accept;
    logic [WIDTH-1:0]  deliver;

`ifdef RNG_ARB_REJECT_EN
    logic [3:0]        tries;
`endif

    lfsr_core #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .state   (lfsr_state)
    );

    // Two passes: requesters at/after rr_ptr first, then the wrapped-around ones.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!req_found && req_i[k] && (PTR_W'(k) >= rr_ptr)) begin
                req_found = 1'b1;
                req_idx   = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!req_found && req_i[k]) begin
                req_found = 1'b1;
                req_idx   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        req_limit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == req_idx) begin
                req_limit = limit_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign mask     = WIDTH'(mask_from_limit(LFSR_W'(limit_q)));
    assign draw_m   = lfsr_state & mask;
    assign in_range = (limit_q == '0) || (draw_m < limit_q);
    // mask < 2L, so the folded value m-L always lands inside [0, L).
    assign deliver  = in_range ? draw_m : (draw_m - limit_q);

`ifdef RNG_ARB_REJECT_EN
    assign accept = in_range || (tries == 4'(MAX_TRIES));
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_found) state_next = ST_DRAW;
            ST_DRAW: if (accept) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            limit_q   <= '0;
            ack_o     <= '0;
            value_o   <= '0;
`ifdef RNG_ARB_REJECT_EN
            tries     <= '0;
`endif
        end else begin
            ack_o <= '0;
            if (state == ST_IDLE && req_found) begin
                grant_idx <= req_idx;
                limit_q   <= req_limit;
`ifdef RNG_ARB_REJECT_EN
                tries     <= '0;
`endif
            end
            if (state == ST_DRAW) begin
                if (accept) begin
                    value_o <= deliver;
                    ack_o   <= NUM_REQ'(1) << grant_idx;
                    rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                end
`ifdef RNG_ARB_REJECT_EN
                else begin
                    tries <= tries + 4'd1;
                end
`endif
            end
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: doc/rng_request_arbiter.md
# rng_request_arbiter

- Shares one free-running random source among up to NUM_REQ game-logic requesters. Each requester asks for a value in [0, limit).
- A round-robin arbiter grants one requester at a time. The block draws from an internal XNOR-feedback LFSR, range-reduces the draw, and returns it with a one-cycle acknowledge.
- It sits between the game FSMs and the random source, so no requester steps the LFSR directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, LFSR and value width; taps fixed for 8 (x^8+x^6+x^5+x^4+1)
- MAX_TRIES, 15, rejection limit per request
- clock_i  input  1  system clock
- reset_i  input  1  asynchronous, active-low reset (clock is clock_i)
- req_i  input  NUM_REQ  per-requester request, level, held until its ack
- limit_i  input  NUM_REQ*WIDTH  per-requester exclusive upper bound, slice k = bits [k*WIDTH +: WIDTH]; 0 means full range
- ack_o  output  NUM_REQ  one-hot, one-cycle pulse; value_o valid in the same cycle
- value_o  output  WIDTH  delivered random value, held until the next ack
- busy_o  output  1  high in DRAW and DONE

## Operation
- LFSR: Fibonacci shift-left, new bit0 = ~(s[7]^s[5]^s[4]^s[3]). It steps on every clock regardless of FSM state.
  - Reset state 0x00. First states: 00, 01, 03, 07, 0F, 1E, 3D, 7A.
  - All-ones is the lockup state and is never reached from reset.
- FSM states are IDLE, DRAW, DONE.
- IDLE:
  - If any req_i bit is set, grant the first set bit at or after rr_ptr, wrapping.
  - Latch grant index g and limit L = limit_i slice g, then go to DRAW.
  - If no request is set, stay in IDLE.
- mask = smallest (2^n - 1) >= L-1. If L=0 or L=1, mask is all-ones or 0 respectively.
- DRAW: m = state & mask. Accept if L==0 or m < L.
  - On accept: value_o <= m, ack_o[g] <= 1, rr_ptr <= g+1 mod NUM_REQ, go to DONE.
- DONE: ack_o clears, go to IDLE.
- Requester rules:
  - A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request.
  - If a requester drops req mid-operation, the operation still completes and the ack pulses anyway.
- Changes to limit_i after the grant are ignored, because L is latched.

## Timing
- Reset values: ack_o=0, value_o=0, busy_o=0, rr_ptr=0, FSM=IDLE, LFSR=0x00. Reset mid-operation aborts the request with no ack.
- Latency from request sampled in IDLE at edge k:
  - Grant at edge k.
  - Accept at edge k+1+r, where r is the number of rejections.
  - ack_o high during the cycle after that edge.
  - Minimum 2 edges; maximum 2+MAX_TRIES edges.
- One grant in flight. Requesters not granted wait; the maximum wait is (NUM_REQ-1) full operations.
- Simultaneous requests are resolved only by rr_ptr.

## Configuration
- RNG_ARB_REJECT_EN defined:
  - Rejection sampling as above.
  - After MAX_TRIES rejections, deliver m - L (always < L, since m <= mask < 2L) and accept.
  - A 4-bit tries counter is cleared at grant.
- RNG_ARB_REJECT_EN undefined:
  - No retry. In the first DRAW cycle deliver m if m < L, else m - L.
  - Latency is fixed at 2 edges and there is no tries counter.

## Structure
- Package rng_arb_pkg holds:
  - the FSM state enum (IDLE, DRAW, DONE)
  - the LFSR tap constant and reset seed
  - a mask-from-limit function
- Sub-module lfsr_core (WIDTH, free-running, outputs state) holds the LFSR; the arbiter instantiates one.

## Test plan
- Basic grant and latency:
  - Stimulus: req_i=0001 with limit 0 held through reset release.
  - Response: grant at edge 1, ack_o=0001 after edge 2, value_o=0x01, busy_o high for 2 cycles.
- Round-robin fairness:
  - Stimulus: req_i=1111 continuously, each requester dropping req after its ack.
  - Response: ack order 0, 1, 2, 3; rr_ptr returns to 0.
- Rejection (REJECT_EN):
  - Stimulus: req_i[1], limit 5, raised after edge 2, so DRAW begins at state 0x07.
  - Response: masked 7, 7, 6, 5 rejected; 0x7A gives 2, accepted; ack_o=0010, value_o=0x02, 6 edges after grant.
- MAX_TRIES fallback:
  - Stimulus: force lfsr_core state (bench override) so m=7 for 15 draws with limit 5.
  - Response: value_o=0x02 (7-5) and ack after try 15.
- No-reject build:
  - Stimulus: same as the rejection test.
  - Response: value_o=0x02 (7-5), ack 2 edges after grant.
- Reset mid-operation:
  - Stimulus: assert reset_i=0 during DRAW.
  - Response: all outputs 0 immediately; no ack after release; the LFSR restarts from 0x00.
